// File: rtl/load_store_unit.sv
// +----------------------------------------------------------------------------+
// | load_store_unit: byte/half/word loads and stores onto a word-only memory,  |
// | with sub-word stores done as read-modify-write.                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ReqValid,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            Size,
  input  logic                  Unsigned,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           WriteData,
  output logic                  Stall,
  output logic [31:0]           LoadData,
  output logic                  LoadValid,
  output logic                  Fault,
  output logic [ADDR_WIDTH-1:0] DmAddress,
  output logic [31:0]           DmWriteData,
  output logic                  DmMemWrite,
  output logic                  DmMemRead,
  input  logic [31:0]           DmReadData
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ACCESS    = 2'd1,
    S_RMW_READ  = 2'd2,
    S_RMW_WRITE = 2'd3
  } state_e;

  localparam logic [1:0] C_SIZE_BYTE = 2'b00;
  localparam logic [1:0] C_SIZE_HALF = 2'b01;
  localparam logic [1:0] C_SIZE_WORD = 2'b10;
  localparam logic [1:0] C_SIZE_BAD  = 2'b11;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic                    load_q, load_d;
  logic [31:0]             merge_q, merge_d;
  logic [31:0]             load_data_q, load_data_d;
  logic                    load_valid_q, load_valid_d;
  logic                    fault_q, fault_d;

  logic                    w_req_active;
  logic                    w_illegal;
  logic [31:0]             w_lane;
  logic [31:0]             w_extended;
  logic [31:0]             w_merged;

  assign w_req_active = ReqValid & (MemRead | MemWrite);
  assign w_illegal    = (MemRead & MemWrite)
                      | (Size == C_SIZE_BAD)
                      | ((Size == C_SIZE_HALF) & Address[0])
                      | ((Size == C_SIZE_WORD) & (Address[1:0] != 2'b00));

  // Selected lane brought down to bit 0, then extended by size.
  assign w_lane = DmReadData >> {addr_q[1:0], 3'b000};

  always_comb begin
    w_extended = w_lane;
    case (size_q)
      C_SIZE_BYTE: w_extended = uns_q ? {24'h0, w_lane[7:0]}
                                      : {{24{w_lane[7]}}, w_lane[7:0]};
      C_SIZE_HALF: w_extended = uns_q ? {16'h0, w_lane[15:0]}
                                      : {{16{w_lane[15]}}, w_lane[15:0]};
      default:     w_extended = w_lane;
    endcase
  end

  always_comb begin
    w_merged = merge_q;
    if (size_q == C_SIZE_BYTE) begin
      w_merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      w_merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    uns_d        = uns_q;
    load_d       = load_q;
    merge_d      = merge_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    fault_d      = 1'b0;
    DmMemRead    = 1'b0;
    DmMemWrite   = 1'b0;
    DmWriteData  = 32'h0;

    case (state_q)
      S_IDLE: begin
        if (w_req_active) begin
          if (w_illegal) begin
            fault_d = 1'b1;
          end else begin
            addr_d  = Address;
            wdata_d = WriteData;
            size_d  = Size;
            uns_d   = Unsigned;
            load_d  = MemRead;
            state_d = (MemRead || (Size == C_SIZE_WORD)) ? S_ACCESS : S_RMW_READ;
          end
        end
      end
      S_ACCESS: begin
        if (load_q) begin
          DmMemRead    = 1'b1;
          load_data_d  = w_extended;
          load_valid_d = 1'b1;
        end else begin
          DmMemWrite  = 1'b1;
          DmWriteData = wdata_q;
        end
        state_d = S_IDLE;
      end
      S_RMW_READ: begin
        DmMemRead = 1'b1;
        merge_d   = DmReadData;
        state_d   = S_RMW_WRITE;
      end
      S_RMW_WRITE: begin
        DmMemWrite  = 1'b1;
        DmWriteData = w_merged;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      load_q       <= 1'b0;
      merge_q      <= 32'h0;
      load_data_q  <= 32'h0;
      load_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      load_q       <= load_d;
      merge_q      <= merge_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      fault_q      <= fault_d;
    end
  end

  assign Stall     = (state_q != S_IDLE);
  assign LoadData  = load_data_q;
  assign LoadValid = load_valid_q;
  assign Fault     = fault_q;
  assign DmAddress = {addr_q[ADDR_WIDTH-1:2], 2'b00};

endmodule

`default_nettype wire
